// File: rtl/axi_datamem_slave.sv
// axi_datamem_slave: AXI4 slave that terminates the core's data-memory master
// port. The store behind it is a word-organised synchronous RAM. The write
// channel (AW/W/B) and the read channel (AR/R) each have their own FSM, so
// neither channel ever stalls the other.
// It supports INCR and FIXED bursts of up to 16 beats and byte strobes.
// Beats outside the RAM return SLVERR.
// Optional macro: AXI_DATAMEM_WRAP_BURST_EN. When it is defined, WRAP bursts
// with len 1, 3, 7 or 15 are legal. Otherwise WRAP runs as INCR with SLVERR.
module axi_datamem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [1:0]            awburst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [3:0] clampLen(input logic [7:0] l);
    return (l > 8'd15) ? 4'd15 : l[3:0];
  endfunction

  // FIXED holds the address. A legal WRAP keeps the incremented low bits
  // inside the aligned (len+1)*4 window. Anything else advances by 4.
  function automatic logic [ADDR_WIDTH-1:0] nextAddr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [3:0]            l,
    input logic                  fixed,
    input logic                  wrap
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = a + ADDR_WIDTH'(4);
    mask = ADDR_WIDTH'({l, 2'b11});
    if (fixed) return a;
    if (wrap)  return (a & ~mask) | (inc & mask);
    return inc;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [3:0] awLenC, arLenC;
  logic       awWrapOk, arWrapOk, awBad, arBad;

  assign awLenC = clampLen(awlen);
  assign arLenC = clampLen(arlen);

`ifdef AXI_DATAMEM_WRAP_BURST_EN
  assign awWrapOk = (awburst == 2'b10) && (awLenC != 4'd0) && ((awLenC & (awLenC + 4'd1)) == 4'd0);
  assign arWrapOk = (arburst == 2'b10) && (arLenC != 4'd0) && ((arLenC & (arLenC + 4'd1)) == 4'd0);
`else
  assign awWrapOk = 1'b0;
  assign arWrapOk = 1'b0;
`endif

  assign awBad = (awburst == 2'b11) || ((awburst == 2'b10) && !awWrapOk);
  assign arBad = (arburst == 2'b11) || ((arburst == 2'b10) && !arWrapOk);

  // ---------------- write channel ----------------
  wState_t               wState_q, wState_d;
  logic [ADDR_WIDTH-1:0] wAddr_q, wAddr_d;
  logic [3:0]            wLen_q, wLen_d, wBeat_q, wBeat_d;
  logic                  wFixed_q, wFixed_d, wWrap_q, wWrap_d, wErr_q, wErr_d;
  logic                  memWe;
  logic [IDXW-1:0]       wIdx;

  assign wIdx = wAddr_q[IDXW+1:2];

  // Write FSM and burst-tracking registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wState_q <= W_IDLE;
      wAddr_q  <= '0;
      wLen_q   <= '0;
      wBeat_q  <= '0;
      wFixed_q <= 1'b0;
      wWrap_q  <= 1'b0;
      wErr_q   <= 1'b0;
    end else begin
      wState_q <= wState_d;
      wAddr_q  <= wAddr_d;
      wLen_q   <= wLen_d;
      wBeat_q  <= wBeat_d;
      wFixed_q <= wFixed_d;
      wWrap_q  <= wWrap_d;
      wErr_q   <= wErr_d;
    end
  end

  // Write next state and outputs. An illegal burst type seeds the error flag
  // at AW time, so a single flag decides bresp.
  always_comb begin
    wState_d = wState_q;
    wAddr_d  = wAddr_q;
    wLen_d   = wLen_q;
    wBeat_d  = wBeat_q;
    wFixed_d = wFixed_q;
    wWrap_d  = wWrap_q;
    wErr_d   = wErr_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = 2'b00;
    memWe    = 1'b0;
    case (wState_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          wAddr_d  = awaddr;
          wLen_d   = awLenC;
          wBeat_d  = 4'd0;
          wFixed_d = (awburst == 2'b00);
          wWrap_d  = awWrapOk;
          wErr_d   = awBad;
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          memWe   = inRange(wAddr_q);
          wErr_d  = wErr_q | !inRange(wAddr_q) | (wlast != (wBeat_q == wLen_q));
          wAddr_d = nextAddr(wAddr_q, wLen_q, wFixed_q, wWrap_q);
          wBeat_d = wBeat_q + 4'd1;
          if (wBeat_q == wLen_q) wState_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = wErr_q ? 2'b10 : 2'b00;
        if (bready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // RAM write port. A reset edge cancels any beat that is in flight.
  always_ff @(posedge aclk) begin
    if (memWe && !areset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wIdx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rState_t               rState_q, rState_d;
  logic [ADDR_WIDTH-1:0] rAddr_q, rAddr_d;
  logic [3:0]            rLen_q, rLen_d, rBeat_q, rBeat_d;
  logic                  rFixed_q, rFixed_d, rWrap_q, rWrap_d, rBad_q, rBad_d;
  logic [1:0]            rResp_q, rResp_d;
  logic                  rLast_q, rLast_d;
  logic [31:0]           rData_q;
  logic                  rClear;
  logic [IDXW-1:0]       rIdx;

  assign rIdx = rAddr_q[IDXW+1:2];

  // Read FSM and per-beat response registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rState_q <= R_IDLE;
      rAddr_q  <= '0;
      rLen_q   <= '0;
      rBeat_q  <= '0;
      rFixed_q <= 1'b0;
      rWrap_q  <= 1'b0;
      rBad_q   <= 1'b0;
      rResp_q  <= 2'b00;
      rLast_q  <= 1'b0;
    end else begin
      rState_q <= rState_d;
      rAddr_q  <= rAddr_d;
      rLen_q   <= rLen_d;
      rBeat_q  <= rBeat_d;
      rFixed_q <= rFixed_d;
      rWrap_q  <= rWrap_d;
      rBad_q   <= rBad_d;
      rResp_q  <= rResp_d;
      rLast_q  <= rLast_d;
    end
  end

  // Read next state and outputs. R_FETCH is the RAM access cycle. R_DATA
  // holds the registered beat until rready.
  always_comb begin
    rState_d = rState_q;
    rAddr_d  = rAddr_q;
    rLen_d   = rLen_q;
    rBeat_d  = rBeat_q;
    rFixed_d = rFixed_q;
    rWrap_d  = rWrap_q;
    rBad_d   = rBad_q;
    rResp_d  = rResp_q;
    rLast_d  = rLast_q;
    rClear   = 1'b0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    case (rState_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rAddr_d  = araddr;
          rLen_d   = arLenC;
          rBeat_d  = 4'd0;
          rFixed_d = (arburst == 2'b00);
          rWrap_d  = arWrapOk;
          rBad_d   = arBad;
          rState_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rResp_d  = (!inRange(rAddr_q) || rBad_q) ? 2'b10 : 2'b00;
        rLast_d  = (rBeat_q == rLen_q);
        rState_d = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          if (rLast_q) begin
            rResp_d  = 2'b00;
            rLast_d  = 1'b0;
            rClear   = 1'b1;
            rState_d = R_IDLE;
          end else begin
            rAddr_d  = nextAddr(rAddr_q, rLen_q, rFixed_q, rWrap_q);
            rBeat_d  = rBeat_q + 4'd1;
            rState_d = R_FETCH;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // RAM read port. Out-of-range beats read as zero. A same-cycle write to
  // the same word lands after this read, so the read returns the old data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rData_q <= '0;
    end else if (rState_q == R_FETCH) begin
      rData_q <= inRange(rAddr_q) ? mem[rIdx] : 32'h0;
    end else if (rClear) begin
      rData_q <= '0;
    end
  end

  assign rdata = rData_q;
  assign rresp = rResp_q;
  assign rlast = rLast_q;

endmodule

// File: tb/tb_axi_datamem_slave.sv
// tb_axi_datamem_slave: directed and randomized bursts against axi_datamem_slave.
// Expected responses come from a word-array model of the RAM. Beat addresses
// are computed arithmetically from the burst rules.
// Define AXI_DATAMEM_WRAP_BURST_EN to expect legal WRAP bursts.
module tb_axi_datamem_slave;

  localparam int DEPTH = 1024;

  logic        aclk, areset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  axi_datamem_slave #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  // Free-running clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Hard stop if the sequence below ever gets stuck.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no completion, expected $finish before time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int effBeats(input logic [7:0] len);
    return (len > 8'd15) ? 16 : int'(len) + 1;
  endfunction

  function automatic bit wrapLegal(input logic [1:0] b, input int n);
`ifdef AXI_DATAMEM_WRAP_BURST_EN
    return (b == 2'b10) && (n == 2 || n == 4 || n == 8 || n == 16);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit burstErr(input logic [1:0] b, input int n);
    return (b == 2'b11) || ((b == 2'b10) && !wrapLegal(b, n));
  endfunction

  // Byte address of beat k: FIXED stays put, a legal WRAP cycles inside its
  // aligned window, and everything else steps by 4 modulo 2^32.
  function automatic logic [31:0] beatAddr(input logic [31:0] s, input int n,
                                           input logic [1:0] b, input int k);
    logic [31:0] sz, base;
    if (b == 2'b00) return s;
    if (wrapLegal(b, n)) begin
      sz   = 32'(n * 4);
      base = s - (s % sz);
      return base + (((s - base) + 32'(4 * k)) % sz);
    end
    return s + 32'(4 * k);
  endfunction

  function automatic bit inRange(input logic [31:0] a);
    return a < 32'(DEPTH * 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_awready"}, awready, 1);
    checkOutput({tag, "_arready"}, arready, 1);
    checkOutput({tag, "_wready"}, wready, 0);
    checkOutput({tag, "_bvalid"}, bvalid, 0);
    checkOutput({tag, "_rvalid"}, rvalid, 0);
    checkOutput({tag, "_bresp"}, bresp, 0);
    checkOutput({tag, "_rresp"}, rresp, 0);
    checkOutput({tag, "_rdata"}, rdata, 0);
    checkOutput({tag, "_rlast"}, rlast, 0);
  endtask

  task automatic sendAw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int guard = 0;
    awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && guard < 20) begin tick(); guard++; end
    checkOutput("awready_wait", awready, 1);
    tick();
    awvalid = 1'b0;
    checkOutput("awready_busy", awready, 0);
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int guard = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && guard < 20) begin tick(); guard++; end
    checkOutput("wready_wait", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Full write burst using wd/ws. The model is updated, then the channel is
  // driven and bresp is checked after bDelay cycles with bready low.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int wlastAt, input int bDelay);
    int n, last;
    logic err;
    logic [31:0] a;
    logic [1:0] expResp;
    n = effBeats(len);
    last = (wlastAt < 0) ? n - 1 : wlastAt;
    err = burstErr(burst, n);
    for (int k = 0; k < n; k++) begin
      a = beatAddr(addr, n, burst, k);
      if (inRange(a)) begin
        for (int j = 0; j < 4; j++)
          if (ws[k][j]) refMem[a[11:2]][8*j +: 8] = wd[k][8*j +: 8];
      end else begin
        err = 1'b1;
      end
      if ((k == last) != (k == n - 1)) err = 1'b1;
    end
    expResp = err ? 2'b10 : 2'b00;
    sendAw(addr, len, burst);
    for (int k = 0; k < n; k++) sendW(wd[k], ws[k], k == last);
    checkOutput("bvalid_latency", bvalid, 1);
    checkOutput("bresp", bresp, expResp);
    checkOutput("wready_in_resp", wready, 0);
    for (int d = 0; d < bDelay; d++) begin
      tick();
      checkOutput("bvalid_hold", bvalid, 1);
      checkOutput("bresp_hold", bresp, expResp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("bvalid_drop", bvalid, 0);
    checkOutput("awready_back", awready, 1);
  endtask

  // Full read burst. Bit i of pat is rready on the i-th cycle rvalid is high,
  // and the cycles after the 32nd all have rready high.
  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] patIn);
    int n, guard;
    logic [31:0] pat, a, expData;
    logic [1:0] expResp;
    bit err, rdy;
    n = effBeats(len);
    err = burstErr(burst, n);
    pat = patIn;
    guard = 0;
    araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && guard < 20) begin tick(); guard++; end
    checkOutput("arready_wait", arready, 1);
    tick();
    arvalid = 1'b0;
    checkOutput("rvalid_fetch", rvalid, 0);
    checkOutput("arready_busy", arready, 0);
    tick();
    checkOutput("rvalid_first", rvalid, 1);
    for (int k = 0; k < n; k++) begin
      a = beatAddr(addr, n, burst, k);
      expData = inRange(a) ? refMem[a[11:2]] : 32'h0;
      expResp = (!inRange(a) || err) ? 2'b10 : 2'b00;
      rdy = 1'b0;
      while (!rdy) begin
        rdy = pat[0];
        pat = {1'b1, pat[31:1]};
        checkOutput("rvalid", rvalid, 1);
        checkOutput("rdata", rdata, expData);
        checkOutput("rresp", rresp, expResp);
        checkOutput("rlast", rlast, (k == n - 1));
        rready = rdy;
        tick();
        rready = 1'b0;
      end
      checkOutput("rvalid_gap", rvalid, 0);
      if (k < n - 1) begin
        tick();
        checkOutput("rvalid_next", rvalid, 1);
      end
    end
    checkOutput("arready_back", arready, 1);
  endtask

  // Directed steps first, then randomized write/read-back pairs.
  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int n, wl, r;

    areset = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arburst = 0; rready = 0;
    repeat (2) tick();
    areset = 1'b0;
    checkIdleOutputs("reset");

    for (int i = 0; i < DEPTH / 16; i++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      applyStimulus(32'(i * 64), 8'd15, 2'b01, -1, 0);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    applyStimulus(32'h10, 8'd0, 2'b01, -1, 1);
    readBurst(32'h10, 8'd0, 2'b01, 32'hFFFFFFFF);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    applyStimulus(32'h20, 8'd0, 2'b01, -1, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    applyStimulus(32'h20, 8'd0, 2'b01, -1, 0);
    readBurst(32'h20, 8'd0, 2'b01, 32'hFFFFFFFF);

    readBurst(32'h40, 8'd3, 2'b01, 32'h0000002D);

    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    applyStimulus(32'h1000, 8'd0, 2'b01, -1, 0);
    readBurst(32'h0, 8'd0, 2'b01, 32'hFFFFFFFF);
    readBurst(32'hFFC, 8'd1, 2'b01, 32'hFFFFFFFF);

    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    applyStimulus(32'h100, 8'd3, 2'b01, 1, 2);
    readBurst(32'h100, 8'd3, 2'b01, 32'hFFFFFFFF);

    sendAw(32'h400, 8'd3, 2'b01);
    for (int k = 0; k < 2; k++) begin
      wd[k] = $urandom;
      refMem[256 + k] = wd[k];
      sendW(wd[k], 4'hF, 1'b0);
    end
    wdata = $urandom; wstrb = 4'hF; wvalid = 1'b1; areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    wvalid = 1'b0;
    checkIdleOutputs("midreset");
    readBurst(32'h400, 8'd3, 2'b01, 32'hFFFFFFFF);

    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'(k + 3); end
    applyStimulus(32'h200, 8'd3, 2'b00, -1, 0);
    readBurst(32'h200, 8'd2, 2'b00, 32'h5);

    readBurst(32'h38, 8'd3, 2'b10, 32'hFFFFFFFF);
    for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    applyStimulus(32'h500, 8'd1, 2'b11, -1, 0);
    readBurst(32'h500, 8'd1, 2'b11, 32'hFFFFFFFF);

    for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    applyStimulus(32'h300, 8'd200, 2'b01, -1, 0);
    readBurst(32'h300, 8'd77, 2'b01, 32'hFFFFFFFF);

    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    applyStimulus(32'hFFFFFFF8, 8'd3, 2'b01, -1, 0);
    readBurst(32'hFFFFFFF8, 8'd3, 2'b01, 32'hFFFFFFFF);

    for (int t = 0; t < 30; t++) begin
      r = int'($urandom_range(0, 9));
      addr = (r < 8) ? 32'($urandom_range(0, 4095)) : 32'h1000 - 32'($urandom_range(0, 40));
      r = int'($urandom_range(0, 9));
      burst = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      n = effBeats(len);
      wl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) % n : -1;
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      applyStimulus(addr, len, burst, wl, int'($urandom_range(0, 2)));
      readBurst(addr, len, burst, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/axi_datamem_slave.md
Name: axi_datamem_slave

Overview:
- AXI4 responder (slave) that terminates the core's data-memory AXI master port; backs a word-organised synchronous RAM.
- Independent write (AW/W/B) and read (AR/R) FSMs, INCR/FIXED bursts up to 16 beats, byte strobes, range checking with SLVERR.
- Sits between the memory stage's master port and on-chip data storage; replaces the ad-hoc memory model in simulation and synthesis.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; in-range byte address is 0 .. DEPTH_WORDS*4-1.
- ADDR_WIDTH, 32, width of awaddr/araddr.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  synchronous, active-high reset.
- awvalid, awready  in, out  1  write-address handshake.
- awaddr  in  ADDR_WIDTH  burst start byte address.
- awlen  in  8  beats-1; values >15 are treated as 15.
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- wvalid, wready  in, out  1  write-data handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte enables; bit i gates wdata[8i+7:8i].
- wlast  in  1  final-beat marker.
- bvalid, bready  out, in  1  write-response handshake.
- bresp  out  2  00 OKAY, 10 SLVERR.
- arvalid, arready  in, out  1  read-address handshake.
- araddr  in  ADDR_WIDTH  burst start byte address.
- arlen  in  8  beats-1; values >15 are treated as 15.
- arburst  in  2  same encoding as awburst.
- rvalid, rready  out, in  1  read-data handshake.
- rdata  out  32  read data.
- rresp  out  2  per-beat response.
- rlast  out  1  asserted on the final beat.

Behaviour:
- Reset (areset=1 at an edge): both FSMs go to IDLE, beat counters and error flags clear, any in-flight burst is abandoned with no further RAM writes.
- Output values in and after reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, rlast=0. RAM contents are not reset.
- Address mapping: word index = addr[ADDR_WIDTH-1:2]. A beat is in range iff addr < DEPTH_WORDS*4. addr[1:0] is ignored: strobes govern writes, reads return the full word.
- Beat address, INCR: +4 per beat, 32-bit wrap-around.
- Beat address, FIXED: unchanged across beats.
- WRAP and reserved (11): processed as INCR, burst response forced to SLVERR.
- Write FSM, W_IDLE: awready=1. On awvalid&&awready, latch addr/len/burst, clear the error flag, go to W_DATA.
- Write FSM, W_DATA: wready=1. On each wvalid&&wready:
  - in range: write the strobed bytes; out of range: no write, set the error flag.
  - If wlast != (beat==len), set the error flag.
  - Exactly len+1 beats are accepted regardless of wlast; after the final beat go to W_RESP.
- Write FSM, W_RESP: bvalid=1, bresp = error flag ? 10 : 00, held stable until bready, then W_IDLE. awready=0 outside W_IDLE.
- Read FSM, R_IDLE: arready=1. On handshake, latch addr/len/burst and go to R_FETCH.
- Read FSM, R_FETCH: one cycle synchronous RAM read, then R_DATA.
- Read FSM, R_DATA:
  - rvalid=1; rdata, rresp and rlast held stable until rready.
  - Out-of-range beat: rdata=0, rresp=10.
  - WRAP/reserved burst: rresp=10 on every beat.
  - On rready: if the beat was the last, go to R_IDLE; otherwise advance the address and go to R_FETCH.
- Latency:
  - AR handshake at edge N gives first rvalid at N+2.
  - Each later beat is valid 2 cycles after the previous rready handshake.
  - Final W beat at edge N gives bvalid at N+1.
- Simultaneous read fetch and write beat to the same word: read returns pre-write data (read-before-write). The FSMs never stall each other.
- Back-to-back: a new AW is accepted only after B completes; a new AR only after the last R handshake.

Optional Feature:
- Macro: AXI_DATAMEM_WRAP_BURST_EN.
- Defined: WRAP bursts are legal when len ∈ {1,3,7,15}.
  - Wrap boundary = (len+1)*4 bytes. Address increments as INCR, but the low log2((len+1)*4) bits wrap within the aligned window.
  - Response is OKAY unless out of range.
  - WRAP with any other len: processed as INCR with SLVERR.
- Undefined: WRAP is treated as INCR with SLVERR, as described in Behaviour.

Test Plan:
- Single write: awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=1111, wlast=1, bready=1 -> bvalid one cycle after the W handshake, bresp=00. Read of 0x10 -> rdata=0xDEADBEEF, rlast=1, rvalid 2 cycles after the AR handshake.
- Byte strobes: word 0x20 = 0x11223344, then write wdata=0xAABBCCDD with wstrb=0101 -> readback 0x11BB33DD.
- 4-beat INCR read at 0x40 (arlen=3) with rready toggling 1,0,1,1,0,1 -> four beats in order, rlast only on beat 4, rdata stable while rvalid && !rready.
- Out of range, DEPTH_WORDS=1024:
  - Write awaddr=0x1000 -> bresp=10, RAM unchanged.
  - Read 2-beat INCR at 0xFFC -> beat 1 rresp=00 with valid data, beat 2 rresp=10 with rdata=0.
- wlast asserted on beat 2 of a 4-beat burst -> all 4 beats accepted, bresp=10.
- areset pulsed during beat 2 of a 4-beat write -> beats 3-4 never written; after reset awready=1, bvalid=0. With the macro defined, a WRAP len=3 read at 0x38 returns words 0x38, 0x3C, 0x30, 0x34 with rresp=00.
